count_monitor: RTL

Downstream checker for the 4-bit free-running counter. It samples the counter's `count` output and verifies the sequence: legal increments, wrap-arounds and restarts to 0. It flags stalls and illegal jumps, and keeps a saturating wrap tally. It sits directly after the counter in the datapath and feeds status to the next stage or to bench scoreboards.

---
 rtl/count_monitor_pkg.sv | 21 ++
 rtl/sat_counter.sv | 32 +++
 rtl/count_monitor.sv | 107 ++++++++++
 3 files changed

// File: rtl/count_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor_pkg
// Brief    : Shared state encoding and sizing helper for count_monitor.
// Revision : 1.0  initial release
// ============================================================================
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TRACK   = 2'b01,
        STALLED = 2'b10
    } state_t;

    // Width that can hold 0..limit inclusive.
    function automatic int stall_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that holds at all-ones.
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor
// Brief    : Checks a free-running counter for legal steps, wraps, restarts,
//            stalls and illegal jumps; keeps a saturating wrap tally.
// Revision : 1.0  initial release
// ============================================================================
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int STALL_LIMIT = 8,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clr_err,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              stall,
    output logic              jump_err
);

    localparam int                 c_cnt_w = stall_cnt_w(STALL_LIMIT);
    localparam logic [WIDTH-1:0]   c_max   = {WIDTH{1'b1}};
    localparam logic [c_cnt_w-1:0] c_hit   = c_cnt_w'(STALL_LIMIT - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_prev;
    logic               r_wrap_pulse;
    logic               r_stall;
    logic               r_jump_err;
    logic [c_cnt_w-1:0] w_stall_cnt;

    logic w_rst, w_live, w_rep, w_inc, w_wrap, w_zero, w_jump, w_hit;

    assign w_rst  = ~reset;
    assign w_live = count_valid && (r_state != IDLE);

    // Classification in priority order; repeat and restart are legal.
    assign w_rep  = (count_in == r_prev);
    assign w_inc  = (count_in == WIDTH'(r_prev + 1'b1)) && (r_prev != c_max);
    assign w_wrap = (r_prev == c_max) && (count_in == '0);
    assign w_zero = (count_in == '0);
    assign w_jump = !(w_inc || w_wrap || w_rep || w_zero);
    assign w_hit  = w_rep && (w_stall_cnt >= c_hit);

    sat_counter #(.W(c_cnt_w)) u_stall_cnt (
        .clk     (clk),
        .rst     (w_rst),
        .i_clr   (w_live && !w_rep),
        .i_inc   (w_live && w_rep),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk     (clk),
        .rst     (w_rst),
        .i_clr   (1'b0),
        .i_inc   (w_live && w_wrap),
        .o_count (wrap_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_prev       <= '0;
            r_wrap_pulse <= 1'b0;
            r_stall      <= 1'b0;
            r_jump_err   <= 1'b0;
        end else begin
            r_wrap_pulse <= 1'b0;
            if (clr_err) begin
                r_jump_err <= 1'b0;
            end
            if (count_valid) begin
                r_prev <= count_in;
                if (r_state == IDLE) begin
                    r_state <= TRACK;
                end else begin
                    if (w_wrap) begin
                        r_wrap_pulse <= 1'b1;
                    end
                    // A fresh jump overrides a simultaneous clear.
                    if (w_jump) begin
                        r_jump_err <= 1'b1;
                    end
                    if (!w_rep) begin
                        r_state <= TRACK;
                        r_stall <= 1'b0;
                    end else if (w_hit) begin
                        r_state <= STALLED;
                        r_stall <= 1'b1;
                    end
                end
            end
        end
    end

    assign wrap_pulse = r_wrap_pulse;
    assign stall      = r_stall;
    assign jump_err   = r_jump_err;

endmodule
`default_nettype wire
